adder_stream_accumulator: RTL and testbench
===========================================

# adder_stream_accumulator

Sequential front-end for the WIDTH-bit carry-lookahead adder. It accepts a stream of operand words over a valid/ready handshake and drives the adder with the running accumulator and the incoming word. It folds the adder's WIDTH+1-bit result back into the accumulator and emits the packet total, a sticky carry-out flag and a beat count when the last word of a packet arrives. The adder instance sits beside this block; the block owns all state.

## Interface
- WIDTH, 8: operand/accumulator width; must match the adder's WIDTH
- CNT_WIDTH, 8: width of the beat counter
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_valid  in  1  input word valid
- o_ready  out  1  block can accept a word this cycle
- i_data  in  WIDTH  input word
- i_last  in  1  qualifies i_data as the final word of a packet
- i_clear  in  1  synchronous abort of the packet in progress
- o_add1  out  WIDTH  adder operand 1 (accumulator)
- o_add2  out  WIDTH  adder operand 2 (i_data)
- i_result  in  WIDTH+1  adder result; bit WIDTH is carry-out
- o_valid  out  1  packet result valid
- i_ready  in  1  downstream accepts the result
- o_sum  out  WIDTH  packet total, modulo 2^WIDTH
- o_overflow  out  1  a carry-out occurred on any beat of the packet
- o_count  out  CNT_WIDTH  accepted beats in the packet, saturating

## Operation
- Two states: ACCUM and DONE. Reset enters ACCUM.
- Internal registers: acc (WIDTH), ovf (1), cnt (CNT_WIDTH). All are zero after reset.
- Adder operands are combinational: o_add1 = acc and o_add2 = i_data, in every state. i_result is used in the same cycle.
- o_ready = (state == ACCUM) & ~i_clear. A beat is accepted when i_valid & o_ready.
- ACCUM, i_clear high: acc, ovf and cnt clear to 0. No beat is accepted. State stays ACCUM. i_clear is ignored in DONE.
- ACCUM, beat accepted with i_last = 0:
  - acc <= i_result[WIDTH-1:0]
  - ovf <= ovf | i_result[WIDTH]
  - cnt <= cnt + 1, holding at 2^CNT_WIDTH - 1 once reached
- ACCUM, beat accepted with i_last = 1:
  - o_sum <= i_result[WIDTH-1:0]
  - o_overflow <= ovf | i_result[WIDTH]
  - o_count <= saturated cnt + 1
  - o_valid <= 1, and the state moves to DONE
- DONE:
  - o_ready = 0
  - o_sum, o_overflow and o_count hold stable while o_valid & ~i_ready
  - When o_valid & i_ready: o_valid <= 0, acc/ovf/cnt clear to 0, and the state returns to ACCUM
- i_valid gaps inside a packet are allowed; state holds.
- A single-beat packet (i_last on the first beat) is legal and yields o_sum = i_data and o_count = 1.
- A wrapped sum is not an error. It only sets o_overflow.

## Timing
- Reset values: o_valid = 0, o_sum = 0, o_overflow = 0, o_count = 0, o_add1 = 0, o_ready = ~i_clear. o_add2 always follows i_data.
- Asserting i_rst_n low at any time, including mid-packet or in DONE, immediately drops o_valid and zeroes all registers. The partial packet is discarded.
- Throughput is one word per cycle in ACCUM.
- Latency: o_valid rises on the clock edge that accepts the i_last beat, so it is visible in the following cycle.
- Each packet costs at least one cycle of o_ready = 0 (the DONE cycle), plus any cycles of downstream backpressure.
- The first beat of the next packet can be accepted in the cycle after the o_valid & i_ready handshake.
- Upstream must keep i_data and i_last stable while i_valid & ~o_ready. Downstream may hold i_ready low indefinitely.
- The adder path is combinational: i_data -> adder -> i_result -> acc. The block must meet timing for one adder delay per cycle.

## Test plan
Defaults WIDTH=8, CNT_WIDTH=8 unless stated.
- Words 0x10, 0x20, 0x30 (last) back-to-back, i_ready=1 -> one cycle after the last beat: o_valid=1, o_sum=0x60, o_overflow=0, o_count=3. o_ready=0 for exactly one cycle.
- Words 0xFF, 0x02 (last) -> o_sum=0x01, o_overflow=1, o_count=2. The next packet 0x05 (last) -> o_sum=0x05, o_overflow=0, o_count=1.
- Packet 0x11 (last) with i_ready held low for 5 cycles -> o_valid, o_sum=0x11 and o_count=1 stay stable and o_ready stays 0 through all 5 cycles. One cycle after i_ready rises, o_valid=0 and o_ready=1.
- Words 0x40, 0x40, then i_clear for one cycle (with i_valid=1, no accept), then 0x01 (last) -> o_sum=0x01, o_overflow=0, o_count=1.
- CNT_WIDTH=2, five words of 0x01 with i_valid gaps between them, last on the fifth -> o_sum=0x05, o_count=3 (saturated).
- Pull i_rst_n low after 0x33 is accepted, and again while in DONE -> o_valid, o_sum and o_count are 0 during reset. After release, packet 0x07 (last) -> o_sum=0x07, o_count=1.

Source files
------------

// File: rtl/adder_stream_accumulator.sv
// Streaming front-end for an external carry-lookahead adder: folds a packet of
// words into a running accumulator and emits total, sticky carry and beat count.
module adder_stream_accumulator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [WIDTH-1:0]     i_data,
    input  logic                 i_last,
    input  logic                 i_clear,
    output logic [WIDTH-1:0]     o_add1,
    output logic [WIDTH-1:0]     o_add2,
    input  logic [WIDTH:0]       i_result,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [WIDTH-1:0]     o_sum,
    output logic                 o_overflow,
    output logic [CNT_WIDTH-1:0] o_count
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t               state;
    state_t               state_next;
    logic [WIDTH-1:0]     acc;
    logic                 ovf;
    logic [CNT_WIDTH-1:0] cnt;
    logic [CNT_WIDTH-1:0] cnt_sat;
    logic                 accept;
    logic                 handshake;

    // Adder operands are driven straight from the accumulator and the input word.
    assign o_add1 = acc;
    assign o_add2 = i_data;

    assign accept    = i_valid & o_ready;
    assign handshake = o_valid & i_ready;
    assign cnt_sat   = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= ACCUM;
        end else begin
            state <= state_next;
        end
    end

    // Next state: leave ACCUM on the last beat, return once the result is taken.
    always_comb begin
        state_next = state;
        case (state)
            ACCUM: if (accept && i_last) state_next = DONE;
            DONE:  if (handshake)        state_next = ACCUM;
            default: state_next = ACCUM;
        endcase
    end

    // Upstream ready: only while accumulating and not being aborted.
    always_comb begin
        o_ready = 1'b0;
        if (state == ACCUM) begin
            o_ready = ~i_clear;
        end
    end

    // Accumulator, sticky carry, beat counter and the registered packet result.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc        <= '0;
            ovf        <= 1'b0;
            cnt        <= '0;
            o_valid    <= 1'b0;
            o_sum      <= '0;
            o_overflow <= 1'b0;
            o_count    <= '0;
        end else if (state == ACCUM) begin
            if (i_clear) begin
                acc <= '0;
                ovf <= 1'b0;
                cnt <= '0;
            end else if (accept) begin
                if (i_last) begin
                    o_sum      <= i_result[WIDTH-1:0];
                    o_overflow <= ovf | i_result[WIDTH];
                    o_count    <= cnt_sat;
                    o_valid    <= 1'b1;
                end else begin
                    acc <= i_result[WIDTH-1:0];
                    ovf <= ovf | i_result[WIDTH];
                    cnt <= cnt_sat;
                end
            end
        end else if (handshake) begin
            o_valid <= 1'b0;
            acc     <= '0;
            ovf     <= 1'b0;
            cnt     <= '0;
        end
    end

endmodule

// File: tb/tb_adder_stream_accumulator.sv
// Directed bench for adder_stream_accumulator: vector table plus hand-written
// sequences for backpressure, reset and counter saturation.
`timescale 1ns/1ps
module tb_adder_stream_accumulator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid, last, clear, rdy_in;
    logic [7:0] data;
    logic       ready;
    logic [7:0] add1, add2, sum, count;
    logic [8:0] result;
    logic       o_valid, ovf;

    logic       b_valid, b_last, b_clear, b_rdy_in;
    logic [7:0] b_data, b_add1, b_add2, b_sum;
    logic [8:0] b_result;
    logic       b_ready, b_o_valid, b_ovf;
    logic [1:0] b_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Behavioural stand-in for the external adder.
    assign result   = {1'b0, add1} + {1'b0, add2};
    assign b_result = {1'b0, b_add1} + {1'b0, b_add2};

    adder_stream_accumulator #(.WIDTH(8), .CNT_WIDTH(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .o_ready(ready),
        .i_data(data), .i_last(last), .i_clear(clear), .o_add1(add1),
        .o_add2(add2), .i_result(result), .o_valid(o_valid), .i_ready(rdy_in),
        .o_sum(sum), .o_overflow(ovf), .o_count(count)
    );

    adder_stream_accumulator #(.WIDTH(8), .CNT_WIDTH(2)) dut_sat (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(b_valid), .o_ready(b_ready),
        .i_data(b_data), .i_last(b_last), .i_clear(b_clear), .o_add1(b_add1),
        .o_add2(b_add2), .i_result(b_result), .o_valid(b_o_valid), .i_ready(b_rdy_in),
        .o_sum(b_sum), .o_overflow(b_ovf), .o_count(b_count)
    );

    typedef struct {
        logic       valid, last, clear, rdy;
        logic [7:0] data;
        logic       e_ready;
        logic [7:0] e_add1;
        logic       e_valid;
        logic [7:0] e_sum;
        logic       e_ovf;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [7:0] s,
                           input logic o, input logic [7:0] c);
        chk({tag, ".o_valid"}, 32'(o_valid), 32'(v));
        chk({tag, ".o_sum"}, 32'(sum), 32'(s));
        chk({tag, ".o_overflow"}, 32'(ovf), 32'(o));
        chk({tag, ".o_count"}, 32'(count), 32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // valid last clear rdy data | ready add1 | valid sum ovf cnt
        vecs[0]  = '{1, 0, 0, 1, 8'h10, 1, 8'h00, 0, 8'h00, 0, 8'd0};
        vecs[1]  = '{1, 0, 0, 1, 8'h20, 1, 8'h10, 0, 8'h00, 0, 8'd0};
        vecs[2]  = '{1, 1, 0, 1, 8'h30, 1, 8'h30, 1, 8'h60, 0, 8'd3};
        vecs[3]  = '{0, 0, 0, 1, 8'h00, 0, 8'h30, 0, 8'h60, 0, 8'd3};
        vecs[4]  = '{1, 0, 0, 1, 8'hFF, 1, 8'h00, 0, 8'h60, 0, 8'd3};
        vecs[5]  = '{1, 1, 0, 1, 8'h02, 1, 8'hFF, 1, 8'h01, 1, 8'd2};
        vecs[6]  = '{1, 1, 0, 1, 8'h05, 0, 8'hFF, 0, 8'h01, 1, 8'd2};
        vecs[7]  = '{1, 1, 0, 1, 8'h05, 1, 8'h00, 1, 8'h05, 0, 8'd1};
        vecs[8]  = '{0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h05, 0, 8'd1};
        vecs[9]  = '{1, 0, 0, 1, 8'h40, 1, 8'h00, 0, 8'h05, 0, 8'd1};
        vecs[10] = '{1, 0, 0, 1, 8'h40, 1, 8'h40, 0, 8'h05, 0, 8'd1};
        vecs[11] = '{1, 1, 1, 1, 8'h01, 0, 8'h80, 0, 8'h05, 0, 8'd1};
        vecs[12] = '{1, 1, 0, 1, 8'h01, 1, 8'h00, 1, 8'h01, 0, 8'd1};
        vecs[13] = '{0, 0, 0, 1, 8'h00, 0, 8'h00, 0, 8'h01, 0, 8'd1};

        rst_n = 1'b0; valid = 0; last = 0; clear = 0; rdy_in = 1; data = 8'h00;
        b_valid = 0; b_last = 0; b_clear = 0; b_rdy_in = 1; b_data = 8'h00;

        // Reset values; o_ready tracks ~i_clear even in reset.
        #2;
        chk_out("reset", 1'b0, 8'h00, 1'b0, 8'd0);
        chk("reset.o_add1", 32'(add1), 32'h0);
        chk("reset.o_ready", 32'(ready), 32'h1);
        clear = 1; #1;
        chk("reset.o_ready_clear", 32'(ready), 32'h0);
        clear = 0; data = 8'h5A; #1;
        chk("reset.o_add2", 32'(add2), 32'h5A);
        data = 8'h00;
        step(); step();
        rst_n = 1'b1;
        step();

        // Table: back-to-back packet, overflow packet, next packet, clear abort.
        for (int i = 0; i < 14; i++) begin
            valid = vecs[i].valid; last = vecs[i].last; clear = vecs[i].clear;
            rdy_in = vecs[i].rdy; data = vecs[i].data;
            #1;
            chk($sformatf("v%0d.o_ready", i), 32'(ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d.o_add1", i), 32'(add1), 32'(vecs[i].e_add1));
            chk($sformatf("v%0d.o_add2", i), 32'(add2), 32'(vecs[i].data));
            step();
            chk_out($sformatf("v%0d", i), vecs[i].e_valid, vecs[i].e_sum,
                    vecs[i].e_ovf, vecs[i].e_cnt);
        end
        valid = 0; last = 0; clear = 0;

        // Backpressure: result held for five cycles with i_ready low.
        valid = 1; last = 1; data = 8'h11; rdy_in = 0;
        step();
        valid = 0; last = 0;
        for (int k = 0; k < 5; k++) begin
            chk_out($sformatf("bp%0d", k), 1'b1, 8'h11, 1'b0, 8'd1);
            chk($sformatf("bp%0d.o_ready", k), 32'(ready), 32'h0);
            step();
        end
        rdy_in = 1;
        step();
        chk("bp_release.o_valid", 32'(o_valid), 32'h0);
        chk("bp_release.o_ready", 32'(ready), 32'h1);

        // Reset mid-packet, then reset while in DONE.
        valid = 1; data = 8'h33;
        step();
        valid = 0;
        chk("mid.o_add1", 32'(add1), 32'h33);
        rst_n = 0; #1;
        chk_out("rst_mid", 1'b0, 8'h00, 1'b0, 8'd0);
        chk("rst_mid.o_add1", 32'(add1), 32'h0);
        step();
        rst_n = 1;
        step();
        valid = 1; last = 1; data = 8'h07; rdy_in = 0;
        step();
        valid = 0; last = 0;
        chk_out("pre_rst_done", 1'b1, 8'h07, 1'b0, 8'd1);
        rst_n = 0; #1;
        chk_out("rst_done", 1'b0, 8'h00, 1'b0, 8'd0);
        chk("rst_done.o_ready", 32'(ready), 32'h1);
        step();
        rst_n = 1; rdy_in = 1;
        step();
        valid = 1; last = 1; data = 8'h07;
        step();
        valid = 0; last = 0;
        chk_out("after_rst", 1'b1, 8'h07, 1'b0, 8'd1);
        step();

        // Two-bit counter saturates at 3 over five gapped beats.
        for (int k = 0; k < 5; k++) begin
            b_valid = 1; b_data = 8'h01; b_last = (k == 4);
            #1;
            chk($sformatf("sat%0d.o_ready", k), 32'(b_ready), 32'h1);
            step();
            if (k == 4) begin
                chk("sat.o_valid", 32'(b_o_valid), 32'h1);
                chk("sat.o_sum", 32'(b_sum), 32'h05);
                chk("sat.o_count", 32'(b_count), 32'h3);
                chk("sat.o_overflow", 32'(b_ovf), 32'h0);
            end
            b_valid = 0; b_last = 0;
            step();
        end
        chk("sat_done.o_valid", 32'(b_o_valid), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
